// File: rtl/uart_rx.sv
// 8N1 UART receiver with single centre sample per bit and a 2-flop input synchroniser.
// Define UART_RX_PARITY_EN for 8E1 framing with even-parity checking.
module uart_rx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       data_received_o,
   output logic       frame_err_o,
   output logic       parity_err_o,
   output logic       busy_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4,
      BRK    = 3'd5
   } state_t;

   state_t        state, state_d;
   logic          rx_meta, rx_s;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          shift_en, good, ferr, perr;
`ifdef UART_RX_PARITY_EN
   logic          par_chk, par_bad;
`endif

   always_comb begin
      state_d  = state;
      shift_en = 1'b0;
      good     = 1'b0;
      ferr     = 1'b0;
      perr     = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_chk  = 1'b0;
`endif
      case (state)
         IDLE:  if (!rx_s) state_d = START;
         // Mid-start-bit check rejects short low glitches.
         START: if (cnt == CNT_HALF) state_d = rx_s ? IDLE : DATA;
         DATA: begin
            if (cnt == CNT_MAX) begin
               shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
               if (bit_idx == 3'd7) state_d = PARITY;
`else
               if (bit_idx == 3'd7) state_d = STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt == CNT_MAX) begin
               par_chk = 1'b1;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (cnt == CNT_MAX) begin
               if (rx_s) begin
                  state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                  perr = par_bad;
                  good = !par_bad;
`else
                  good = 1'b1;
`endif
               end else begin
                  ferr    = 1'b1;
                  state_d = BRK;
               end
            end
         end
         // Held-low line: one frame error only, wait for release.
         BRK:     if (rx_s) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rx_meta         <= 1'b1;
         rx_s            <= 1'b1;
         state           <= IDLE;
         cnt             <= '0;
         bit_idx         <= 3'd0;
         shift           <= 8'h00;
         data_o          <= 8'h00;
         data_received_o <= 1'b0;
         frame_err_o     <= 1'b0;
      end else begin
         rx_meta         <= rx_i;
         rx_s            <= rx_meta;
         state           <= state_d;
         cnt             <= (state_d != state || cnt == CNT_MAX) ? '0 : cnt + 1'b1;
         data_received_o <= good;
         frame_err_o     <= ferr;
         if (state == START) bit_idx <= 3'd0;
         if (shift_en) begin
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
         if (good) data_o <= shift;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         par_bad      <= 1'b0;
         parity_err_o <= 1'b0;
      end else begin
         parity_err_o <= perr;
         if (par_chk) par_bad <= rx_s ^ (^shift);
      end
   end
`else
   assign parity_err_o = 1'b0;
`endif

   assign busy_o = (state != IDLE);

endmodule
